// File: rtl/lcb_responder.sv
// rtl/lcb_responder.sv - multi-slave LCB answer engine with built-in 8N1 serialiser
//
// Purpose: accepts decoded request bytes {CMD, slave}. For each accepted request it
// drives one RS485 answer frame: a turnaround guard, an echo of the request, the
// slave's ROM payload, an XOR checksum, and then a hold time. Everything runs on
// clk, with one UART bit lasting CLK_DIV clock cycles.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   iValid    one-cycle strobe qualifying iData
//   iData     received request byte
//   rom_addr  answer ROM address {slave, byte_index}
//   rom_data  answer ROM data, latency up to CLK_DIV-1 cycles
//   tx        serial output, 8N1, LSB first, idle high
//   dirTX     RS485 driver enable
//   dirRX     RS485 receiver disable, identical to dirTX
//   busy      high from request acceptance until the frame ends
//   oDrop     one-cycle pulse: a valid request arrived while busy
//   oDone     one-cycle pulse at frame end
module lcb_responder #(
  parameter int         CLK_DIV   = 17,
  parameter int         N_SLAVES  = 4,
  parameter int         SLV_W     = 2,
  parameter int         IDX_W     = 5,
  parameter int         FRAME_LEN = 16,
  parameter logic [3:0] CMD       = 4'hA,
  parameter int         TURN_CYC  = 8,
  parameter int         HOLD_CYC  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iValid,
  input  logic [7:0]             iData,
  output logic [SLV_W+IDX_W-1:0] rom_addr,
  input  logic [7:0]             rom_data,
  output logic                   tx,
  output logic                   dirTX,
  output logic                   dirRX,
  output logic                   busy,
  output logic                   oDrop,
  output logic                   oDone
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int GRD_MAX = (TURN_CYC > HOLD_CYC) ? TURN_CYC : HOLD_CYC;
  localparam int GRD_W   = (GRD_MAX > 1) ? $clog2(GRD_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [GRD_W-1:0] TURN_LAST = GRD_W'(TURN_CYC - 1);
  localparam logic [GRD_W-1:0] HOLD_LAST = GRD_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  // Address updates stop once the last payload byte's address has been presented.
  localparam logic [IDX_W:0]   ADDR_LIM  = (IDX_W+1)'(FRAME_LEN - 3);
  localparam logic [4:0]       SLV_LIM   = 5'(N_SLAVES);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_START, S_DATA, S_STOP, S_HOLD} state_t;

  state_t           state, state_n;
  logic [7:0]       req;
  logic [SLV_W-1:0] slv;
  logic [7:0]       csum;
  logic [7:0]       shifter;
  logic [IDX_W-1:0] byte_idx;
  logic [IDX_W-1:0] next_idx;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [GRD_W-1:0] guard_cnt;

  logic req_ok, bit_end, turn_end, hold_end, frame_last, accept, drop;

  assign req_ok     = iValid && (iData[7:4] == CMD) && ({1'b0, iData[3:0]} < SLV_LIM);
  assign bit_end    = (div_cnt == DIV_LAST);
  assign turn_end   = (state == S_TURN) && (guard_cnt == TURN_LAST);
  assign hold_end   = (state == S_HOLD) && (guard_cnt == HOLD_LAST);
  assign frame_last = (byte_idx == LAST_IDX);
  assign next_idx   = byte_idx + IDX_W'(1);
  // On the final hold cycle the engine counts as free, so a request there starts a new frame.
  assign accept     = req_ok && ((state == S_IDLE) || hold_end);
  assign drop       = req_ok && !accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != S_IDLE);
    dirTX   = busy;
    dirRX   = busy;
    tx      = 1'b1;
    case (state)
      S_IDLE:  if (accept) state_n = S_TURN;
      S_TURN:  if (turn_end) state_n = S_START;
      S_START: begin
        tx = 1'b0;
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        tx = shifter[0];
        if (bit_end && (bit_cnt == 3'd7)) state_n = S_STOP;
      end
      S_STOP:  if (bit_end) state_n = frame_last ? S_HOLD : S_START;
      S_HOLD:  if (hold_end) state_n = accept ? S_TURN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req       <= '0;
      slv       <= '0;
      csum      <= '0;
      shifter   <= '0;
      rom_addr  <= '0;
      byte_idx  <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      guard_cnt <= '0;
      oDrop     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      oDrop <= drop;
      oDone <= hold_end;
      if (accept) begin
        req       <= iData;
        slv       <= iData[SLV_W-1:0];
        csum      <= iData;
        rom_addr  <= {iData[SLV_W-1:0], IDX_W'(1)};
        guard_cnt <= '0;
      end else begin
        case (state)
          S_TURN: begin
            if (turn_end) begin
              shifter  <= req;
              byte_idx <= '0;
              div_cnt  <= '0;
            end else begin
              guard_cnt <= guard_cnt + GRD_W'(1);
            end
          end
          S_START: begin
            div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
            if (bit_end) bit_cnt <= '0;
          end
          S_DATA: begin
            div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
            if (bit_end) begin
              shifter <= {1'b0, shifter[7:1]};
              if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
            end
          end
          S_STOP: begin
            div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
            if (bit_end) begin
              if (frame_last) begin
                guard_cnt <= '0;
              end else begin
                // Byte boundary: load the next byte and present the ROM address one byte ahead.
                byte_idx <= next_idx;
                if (next_idx == LAST_IDX) begin
                  shifter <= csum;
                end else begin
                  shifter <= rom_data;
                  csum    <= csum ^ rom_data;
                end
                if ({1'b0, byte_idx} < ADDR_LIM) rom_addr <= {slv, next_idx + IDX_W'(1)};
              end
            end
          end
          S_HOLD: if (!hold_end) guard_cnt <= guard_cnt + GRD_W'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcb_responder.sv
// tb/tb_lcb_responder.sv - directed self-checking bench for lcb_responder
module tb_lcb_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic [6:0] rom_addr;
  logic [7:0] rom_data = 8'h00;
  logic [7:0] rom_pipe = 8'h00;
  logic       tx, dirTX, dirRX, busy, oDrop, oDone;

  int n_cmp  = 0;
  int n_fail = 0;
  logic tx_log [1:177];

  always #5 clk = ~clk;

  // ROM contents are {0, rom_addr}, returned two cycles after the address.
  always @(posedge clk) begin
    rom_pipe <= {1'b0, rom_addr};
    rom_data <= rom_pipe;
  end

  lcb_responder #(
    .CLK_DIV(4), .N_SLAVES(4), .SLV_W(2), .IDX_W(5), .FRAME_LEN(4),
    .CMD(4'hA), .TURN_CYC(8), .HOLD_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .iValid(iValid), .iData(iData),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .tx(tx), .dirTX(dirTX), .dirRX(dirRX), .busy(busy), .oDrop(oDrop), .oDone(oDone)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (dirTX !== 1'b0 || dirRX !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b%b want 00", dirTX, dirRX); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (oDrop !== 1'b0 || oDone !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got drop=%b done=%b want 0 0", oDrop, oDone); end
    n_cmp++; if (rom_addr !== 7'h00) begin n_fail++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // One complete frame observed cycle by cycle; n counts clock edges after the request cycle.
  task automatic run_frame(input logic [7:0] req, input logic [31:0] exp, input bit pre,
                           input int inj_n, input logic [7:0] inj_byte, input bit chain,
                           input logic [7:0] chain_byte, input int exp_drops, input string tag);
    logic [7:0] rx [0:3];
    logic [9:0] sh;
    int b, p, last_n, drops, dones, bad_dir, bad_frm, bad_idle;
    sh = '0; drops = 0; dones = 0; bad_dir = 0; bad_frm = 0; bad_idle = 0;
    for (int i = 0; i < 4; i++) rx[i] = 8'hxx;
    if (!pre) begin
      @(negedge clk);
      n_cmp++; if (dirTX !== 1'b0) begin n_fail++; $display("FAIL %s dir_before: got %b want 0", tag, dirTX); end
      iValid = 1'b1; iData = req;
    end
    last_n = chain ? 176 : 177;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (n == 1 || n == inj_n + 1) iValid = 1'b0;
      if (n == inj_n) begin iValid = 1'b1; iData = inj_byte; end
      if (chain && n == 176) begin iValid = 1'b1; iData = chain_byte; end
      tx_log[n] = tx;
      if (dirRX !== dirTX) bad_dir++;
      if (n <= 176 && (dirTX !== 1'b1 || busy !== 1'b1)) bad_dir++;
      if (oDrop === 1'b1) drops++;
      if (n >= 2 && n <= 176 && oDone === 1'b1) dones++;
      if ((n <= 8 || (n >= 169 && n <= 176)) && tx !== 1'b1) bad_idle++;
      if (n == 1) begin
        n_cmp++; if (rom_addr !== {req[1:0], 5'd1}) begin n_fail++; $display("FAIL %s rom_addr_accept: got %h want %h", tag, rom_addr, {req[1:0], 5'd1}); end
        if (pre) begin
          n_cmp++; if (oDone !== 1'b1) begin n_fail++; $display("FAIL %s prev_done: got %b want 1", tag, oDone); end
        end
      end
      if (n >= 9 && n <= 168 && ((n - 9) % 4) == 2) begin
        b = (n - 9) / 40;
        p = ((n - 9) % 40) / 4;
        sh[p] = tx;
        if (p == 9) begin
          rx[b] = sh[8:1];
          if (sh[0] !== 1'b0 || sh[9] !== 1'b1) bad_frm++;
        end
      end
      if (n == 177) begin
        n_cmp++; if (dirTX !== 1'b0 || dirRX !== 1'b0) begin n_fail++; $display("FAIL %s dir_fall: got %b%b want 00", tag, dirTX, dirRX); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_fall: got %b want 0", tag, busy); end
        n_cmp++; if (oDone !== 1'b1) begin n_fail++; $display("FAIL %s done_pulse: got %b want 1", tag, oDone); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rx[i] !== exp[31-8*i -: 8]) begin
        n_fail++; $display("FAIL %s byte%0d: got %h want %h", tag, i, rx[i], exp[31-8*i -: 8]);
      end
    end
    n_cmp++; if (bad_frm != 0) begin n_fail++; $display("FAIL %s framing: got %0d bad start/stop bits want 0", tag, bad_frm); end
    n_cmp++; if (bad_idle != 0) begin n_fail++; $display("FAIL %s guard_idle: got %0d non-idle cycles want 0", tag, bad_idle); end
    n_cmp++; if (bad_dir != 0) begin n_fail++; $display("FAIL %s dir_busy: got %0d bad cycles want 0", tag, bad_dir); end
    n_cmp++; if (drops != exp_drops) begin n_fail++; $display("FAIL %s drops: got %0d want %0d", tag, drops, exp_drops); end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL %s early_done: got %0d want 0", tag, dones); end
  endtask

  task automatic test_basic_frame();
    run_frame(8'hA2, 32'hA2_41_42_A1, 1'b0, 0, 8'h00, 1'b0, 8'h00, 0, "frame_a2");
  endtask

  task automatic test_bit_timing();
    run_frame(8'hA0, 32'hA0_01_02_A3, 1'b0, 0, 8'h00, 1'b0, 8'h00, 0, "frame_a0");
    n_cmp++;
    if ({tx_log[8], tx_log[9]} !== 2'b10) begin
      n_fail++; $display("FAIL start_edge: got %b%b want 10", tx_log[8], tx_log[9]);
    end
    n_cmp++;
    if ({tx_log[12], tx_log[13], tx_log[32], tx_log[33], tx_log[36], tx_log[37]} !== 6'b000110) begin
      n_fail++;
      $display("FAIL bit_width: got %b want 000110",
               {tx_log[12], tx_log[13], tx_log[32], tx_log[33], tx_log[36], tx_log[37]});
    end
  endtask

  task automatic test_invalid();
    logic [7:0] bad_reqs [0:2];
    int bad;
    bad_reqs[0] = 8'hB1; bad_reqs[1] = 8'hA4; bad_reqs[2] = 8'h3F;
    for (int i = 0; i < 3; i++) begin
      bad = 0;
      @(negedge clk);
      iValid = 1'b1; iData = bad_reqs[i];
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        iValid = 1'b0;
        if (dirTX !== 1'b0 || dirRX !== 1'b0 || busy !== 1'b0 || oDrop !== 1'b0 || tx !== 1'b1) bad++;
      end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL invalid_%h: got %0d active cycles want 0", bad_reqs[i], bad); end
    end
  endtask

  task automatic test_drop();
    int bad;
    bad = 0;
    run_frame(8'hA1, 32'hA1_21_22_A2, 1'b0, 100, 8'hA3, 1'b0, 8'h00, 1, "frame_drop");
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (dirTX !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL drop_not_queued: got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_back_to_back();
    run_frame(8'hA2, 32'hA2_41_42_A1, 1'b0, 0, 8'h00, 1'b1, 8'hA3, 0, "b2b_first");
    run_frame(8'hA3, 32'hA3_61_62_A0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    iValid = 1'b1; iData = 8'hA1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      iValid = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_busy: got %b want 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    n_cmp++; if (dirTX !== 1'b0 || dirRX !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dir: got %b%b want 00", dirTX, dirRX); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(8'hA2, 32'hA2_41_42_A1, 1'b0, 0, 8'h00, 1'b0, 8'h00, 0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_bit_timing();
    test_invalid();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
